// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, price arbitration, dispense handshake, change return.
// Optional idle auto-refund is enabled by defining VEND_TIMEOUT_EN.
module vend_sequencer #(
    parameter int CREDIT_W    = 3,
    parameter int CREDIT_MAX  = 7,
    parameter int PRICE_LO    = 2,
    parameter int PRICE_HI    = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin,
    input  logic                cancel,
    input  logic                sel_valid,
    input  logic [2:0]          sel_code,
    output logic                sel_ack,
    output logic                sel_nak,
    output logic                disp_req,
    output logic [2:0]          disp_code,
    input  logic                disp_done,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

    localparam logic [CREDIT_W-1:0] C_MAX = CREDIT_W'(CREDIT_MAX);
    localparam logic [CREDIT_W-1:0] P_LO  = CREDIT_W'(PRICE_LO);
    localparam logic [CREDIT_W-1:0] P_HI  = CREDIT_W'(PRICE_HI);

    state_t                state, state_nxt;
    logic [CREDIT_W-1:0]   credit_nxt, price;
    logic [2:0]            code_nxt;
    logic                  ack_nxt, nak_nxt, req_nxt, pulse_nxt, rej_nxt, busy_nxt;

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] idle_cnt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            credit       <= '0;
            sel_ack      <= 1'b0;
            sel_nak      <= 1'b0;
            disp_req     <= 1'b0;
            disp_code    <= 3'd0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            sel_ack      <= ack_nxt;
            sel_nak      <= nak_nxt;
            disp_req     <= req_nxt;
            disp_code    <= code_nxt;
            change_pulse <= pulse_nxt;
            coin_reject  <= rej_nxt;
            busy         <= busy_nxt;
        end
    end

    // Coin beats cancel beats selection; a pending selection is re-evaluated next cycle.
    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        code_nxt   = disp_code;
        req_nxt    = disp_req;
        ack_nxt    = 1'b0;
        nak_nxt    = 1'b0;
        pulse_nxt  = 1'b0;
        rej_nxt    = 1'b0;
        price      = sel_code[2] ? P_HI : P_LO;

        case (state)
            ST_IDLE, ST_CREDIT: begin
                if (coin) begin
                    if (credit < C_MAX) begin
                        credit_nxt = credit + 1'b1;
                        state_nxt  = ST_CREDIT;
                    end else begin
                        rej_nxt = 1'b1;
                    end
                end else if (cancel && state == ST_CREDIT) begin
                    state_nxt = ST_CHANGE;
                    nak_nxt   = sel_valid;
                end else if (sel_valid) begin
                    if (credit >= price) begin
                        ack_nxt    = 1'b1;
                        credit_nxt = credit - price;
                        code_nxt   = sel_code;
                        req_nxt    = 1'b1;
                        state_nxt  = ST_DISPENSE;
                    end else begin
                        nak_nxt = 1'b1;
                    end
                end
`ifdef VEND_TIMEOUT_EN
                else if (state == ST_CREDIT && idle_cnt == TO_LAST) begin
                    state_nxt = ST_CHANGE;
                end
`endif
            end
            ST_DISPENSE: begin
                rej_nxt = coin;
                nak_nxt = sel_valid;
                if (disp_done) begin
                    req_nxt   = 1'b0;
                    state_nxt = (credit != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                rej_nxt = coin;
                nak_nxt = sel_valid;
                // Alternate high/low so each returned unit is a separate one-cycle pulse.
                if (change_pulse) begin
                    if (credit == '0) state_nxt = ST_IDLE;
                end else if (credit != '0) begin
                    pulse_nxt  = 1'b1;
                    credit_nxt = credit - 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt == ST_DISPENSE) || (state_nxt == ST_CHANGE);
    end

`ifdef VEND_TIMEOUT_EN
    // Counts quiet cycles in CREDIT; any panel activity restarts it, busy states freeze it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state == ST_IDLE || state == ST_CREDIT) begin
            if (coin || cancel || sel_valid || state_nxt != ST_CREDIT)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a purchase-level reference model.
module tb_vend_sequencer;

    localparam int TO_CYC = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin, cancel, sel_valid, disp_done;
    logic [2:0] sel_code;
    logic       sel_ack, sel_nak, disp_req, change_pulse, coin_reject, busy;
    logic [2:0] disp_code;
    logic [2:0] credit;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    vend_sequencer #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .reset(reset), .coin(coin), .cancel(cancel),
        .sel_valid(sel_valid), .sel_code(sel_code), .sel_ack(sel_ack), .sel_nak(sel_nak),
        .disp_req(disp_req), .disp_code(disp_code), .disp_done(disp_done),
        .change_pulse(change_pulse), .coin_reject(coin_reject), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: credit as a number, a dispensing flag, and a refund described by
    // its start cycle and amount (pulses on odd offsets, done after 2*amount cycles).
    int m_credit, m_code, m_ref_start, m_ref_amt, m_idle, cyc;
    bit m_disp;
    bit e_ack, e_nak, e_rej, e_pulse;

    function automatic void start_refund();
        m_ref_start = cyc;
        m_ref_amt   = m_credit;
        m_idle      = 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_credit = 0; m_code = 0; m_ref_start = -1; m_ref_amt = 0; m_idle = 0;
            cyc = 0; m_disp = 0;
            e_ack = 0; e_nak = 0; e_rej = 0; e_pulse = 0;
        end else begin
            cyc++;
            e_ack = 0; e_nak = 0; e_rej = 0; e_pulse = 0;
            if (m_ref_start >= 0) begin
                int k;
                k = cyc - m_ref_start;
                e_rej = coin;
                e_nak = sel_valid;
                if (k >= 2 * m_ref_amt) begin
                    m_ref_start = -1;
                    m_credit    = 0;
                end else begin
                    e_pulse  = (k % 2) == 1;
                    m_credit = m_ref_amt - (k + 1) / 2;
                end
            end else if (m_disp) begin
                e_rej = coin;
                e_nak = sel_valid;
                if (disp_done) begin
                    m_disp = 0;
                    if (m_credit > 0) start_refund();
                end
            end else begin
                int price;
                price = sel_code[2] ? 4 : 2;
                if (coin || cancel || sel_valid) m_idle = 0;
                else if (m_credit > 0) m_idle++;
                if (coin) begin
                    if (m_credit < 7) m_credit++;
                    else e_rej = 1;
                end else if (cancel && m_credit > 0) begin
                    start_refund();
                    e_nak = sel_valid;
                end else if (sel_valid) begin
                    if (m_credit >= price) begin
                        e_ack    = 1;
                        m_credit = m_credit - price;
                        m_code   = int'(sel_code);
                        m_disp   = 1;
                    end else begin
                        e_nak = 1;
                    end
                end
`ifdef VEND_TIMEOUT_EN
                if (!(coin || cancel || sel_valid) && m_credit > 0 && m_idle >= TO_CYC)
                    start_refund();
`endif
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("m_credit",  int'(credit),       m_credit);
            checkOutput("m_ack",     int'(sel_ack),      int'(e_ack));
            checkOutput("m_nak",     int'(sel_nak),      int'(e_nak));
            checkOutput("m_reject",  int'(coin_reject),  int'(e_rej));
            checkOutput("m_pulse",   int'(change_pulse), int'(e_pulse));
            checkOutput("m_req",     int'(disp_req),     int'(m_disp));
            checkOutput("m_busy",    int'(busy),         int'(m_disp || m_ref_start >= 0));
            if (m_disp) checkOutput("m_code", int'(disp_code), m_code);
        end
    end

    task automatic applyStimulus(input bit c, input bit x, input bit sv, input int code, input bit d);
        coin = c; cancel = x; sel_valid = sv; sel_code = 3'(code); disp_done = d;
        @(posedge clk); #2;
        coin = 0; cancel = 0; disp_done = 0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((busy || credit != 0) && n < 40) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (!busy && credit != 0) applyStimulus(0, 1, 0, 0, 0);
            n++;
        end
        checkOutput(name, int'(!busy && credit == 0), 1);
    endtask

    initial begin
        int q[$];
        coin = 0; cancel = 0; sel_valid = 0; sel_code = 0; disp_done = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #2 reset = 0;
        chk_en = 1;
        checkOutput("rst_credit", int'(credit), 0);
        checkOutput("rst_req",    int'(disp_req), 0);
        checkOutput("rst_code",   int'(disp_code), 0);
        checkOutput("rst_busy",   int'(busy), 0);
        checkOutput("rst_pulse",  int'(change_pulse), 0);

        $display("[TB] three coins, product 1");
        repeat (3) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t1_credit3", int'(credit), 3);
        applyStimulus(0, 0, 1, 1, 0);
        sel_valid = 0;
        checkOutput("t1_ack",     int'(sel_ack), 1);
        checkOutput("t1_credit1", int'(credit), 1);
        checkOutput("t1_req",     int'(disp_req), 1);
        checkOutput("t1_code",    int'(disp_code), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_busy",    int'(busy), 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t1_req_off", int'(disp_req), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_pulse",   int'(change_pulse), 1);
        checkOutput("t1_credit0", int'(credit), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t1_idle",    int'(busy), 0);

        $display("[TB] one coin, product 5 too expensive");
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 5, 0);
        sel_valid = 0;
        checkOutput("t2_nak",    int'(sel_nak), 1);
        checkOutput("t2_credit", int'(credit), 1);
        checkOutput("t2_req",    int'(disp_req), 0);
        applyStimulus(0, 1, 0, 0, 0);
        waitIdle("t2_drain");

        $display("[TB] overfill and full refund");
        repeat (7) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t3_credit7", int'(credit), 7);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t3_reject",  int'(coin_reject), 1);
        checkOutput("t3_still7",  int'(credit), 7);
        applyStimulus(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (change_pulse) q.push_back(i);
        end
        checkOutput("t3_pulses", q.size(), 7);
        for (int i = 1; i < q.size(); i++) checkOutput("t3_gap", q[i] - q[i-1], 2);
        checkOutput("t3_credit0", int'(credit), 0);
        checkOutput("t3_idle",    int'(busy), 0);

        $display("[TB] coin and selection in the same cycle");
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("t4_credit2", int'(credit), 2);
        checkOutput("t4_no_ack",  int'(sel_ack | sel_nak), 0);
        applyStimulus(0, 0, 1, 0, 0);
        sel_valid = 0;
        checkOutput("t4_ack",     int'(sel_ack), 1);
        checkOutput("t4_credit0", int'(credit), 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t4_idle",    int'(busy), 0);

        $display("[TB] reset during dispense");
        repeat (2) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        sel_valid = 0;
        checkOutput("t5_req_on", int'(disp_req), 1);
        reset = 1;
        #1;
        checkOutput("t5_req",    int'(disp_req), 0);
        checkOutput("t5_credit", int'(credit), 0);
        checkOutput("t5_busy",   int'(busy), 0);
        @(posedge clk); #2 reset = 0;

        $display("[TB] idle with credit");
        repeat (2) applyStimulus(1, 0, 0, 0, 0);
`ifdef VEND_TIMEOUT_EN
        q.delete();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (change_pulse) q.push_back(i);
        end
        checkOutput("t6_pulses", q.size(), 2);
        checkOutput("t6_credit", int'(credit), 0);
`else
        repeat (1000) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t6_credit", int'(credit), 2);
        checkOutput("t6_busy",   int'(busy), 0);
        applyStimulus(0, 1, 0, 0, 0);
`endif
        waitIdle("t6_drain");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            bit c, x, d;
            c = ($urandom % 5) == 0;
            x = ($urandom % 20) == 0;
            d = disp_req ? (($urandom % 4) == 0) : (($urandom % 40) == 0);
            if (sel_valid && (sel_ack || sel_nak)) sel_valid = 0;
            else if (!sel_valid && ($urandom % 6) == 0) begin
                sel_valid = 1;
                sel_code  = 3'($urandom % 8);
            end
            applyStimulus(c, x, sel_valid, int'(sel_code), d);
        end
        sel_valid = 0;
        for (int i = 0; i < 8 && disp_req; i++) applyStimulus(0, 0, 0, 0, 1);
        waitIdle("rand_drain");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
